// File: rtl/boreal_ctrl_pkg.sv
// Shared types and helpers for the Boreal multi-channel velocity controller:
// FSM encoding, default gain/damping shifts and the symmetric saturator.
package boreal_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int DEF_K_SHIFT = 3;
    localparam int DEF_D_SHIFT = 4;

    typedef struct packed {
        logic signed [63:0] value;
        logic               clamped;
    } sat_t;

    // Clamp to +/-(2**(w-1)-1); the most negative code is never produced so
    // the magnitude of a stored value always fits in w-1 bits.
    function automatic sat_t sat_sym(input logic signed [63:0] value, input int w);
        logic signed [63:0] lim;
        sat_t               r;
        lim       = (64'sd1 <<< (w - 1)) - 64'sd1;
        r.value   = value;
        r.clamped = 1'b0;
        if (value > lim) begin
            r.value   = lim;
            r.clamped = 1'b1;
        end else if (value < -lim) begin
            r.value   = -lim;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/boreal_velocity_pwm_dds.sv
// Sign/magnitude DDS PWM: an MW-bit phase accumulator whose carry-out is the
// PWM bit, so the duty cycle is exactly mag / 2**MW.
module boreal_dds_pwm #(
    parameter int MW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clr,
    input  logic [MW-1:0] mag,
    output logic          pwm
);

    logic [MW-1:0] acc;
    logic [MW:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pwm <= 1'b0;
        end else if (clr || !enable) begin
            acc <= '0;
            pwm <= 1'b0;
        end else begin
            acc <= sum[MW-1:0];
            pwm <= sum[MW];
        end
    end

endmodule

// File: rtl/boreal_velocity_pwm_mc.sv
// Multi-channel 2nd-order velocity controller: one shared update datapath
// behind a valid/ready sample port, per-channel saturation flags and DDS PWM.
module boreal_velocity_pwm_mc
    import boreal_ctrl_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int W       = 16,
    parameter int K_SHIFT = DEF_K_SHIFT,
    parameter int D_SHIFT = DEF_D_SHIFT,
    parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clr,
    input  logic                mu_valid,
    output logic                mu_ready,
    input  logic [CH_W-1:0]     mu_ch,
    input  logic signed [W-1:0] mu,
    input  logic                sat_clr,
    output logic [NCH-1:0]      pwm,
    output logic [NCH-1:0]      dir,
    output logic [NCH-1:0]      sat_flag,
    output logic                busy
);

    localparam int WE = W + 2;

    state_t              state;
    logic [CH_W-1:0]     ch_q;
    logic signed [W-1:0] mu_q;
    logic signed [W-1:0] v_q [NCH];
    logic signed [W-1:0] x_q [NCH];
    logic [NCH-1:0]      dir_q;
    logic [NCH-1:0]      sat_q;

    logic                ch_ok;
    logic [CH_W-1:0]     ch_idx;
    logic signed [W-1:0] v_cur;
    logic signed [W-1:0] x_cur;
    logic signed [WE-1:0] v_sum;
    logic signed [WE-1:0] x_sum;
    sat_t                v_sat;
    sat_t                x_sat;
    logic                unused_sat_hi;

    // rst_n gates the port so no sample is offered while reset is asserted.
    assign mu_ready = rst_n & (state == IDLE) & enable & ~clr;
    assign busy     = (state == CALC);
    assign dir      = dir_q;
    assign sat_flag = sat_q;

    assign ch_ok  = 32'(ch_q) < NCH;
    assign ch_idx = ch_ok ? ch_q : '0;
    assign v_cur  = v_q[ch_idx];
    assign x_cur  = x_q[ch_idx];

    // x integrates the OLD velocity; both sums are widened so nothing wraps
    // before the clamp sees them.
    assign v_sum = WE'(v_cur) + WE'(mu_q >>> K_SHIFT) - WE'(v_cur >>> D_SHIFT);
    assign x_sum = WE'(x_cur) + WE'(v_cur);
    assign v_sat = sat_sym(64'(v_sum), W);
    assign x_sat = sat_sym(64'(x_sum), W);
    assign unused_sat_hi = ^{v_sat.value[63:W], x_sat.value[63:W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch_q  <= '0;
            mu_q  <= '0;
            dir_q <= '0;
            sat_q <= '0;
            // NOTE: v/x are small register arrays, not RAM, so they take the
            // async reset like any other state.
            for (int i = 0; i < NCH; i++) begin
                v_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            if (sat_clr) sat_q <= '0;
            if (clr) begin
                state <= IDLE;
                dir_q <= '0;
                for (int i = 0; i < NCH; i++) begin
                    v_q[i] <= '0;
                    x_q[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: if (mu_valid && mu_ready) begin
                        ch_q  <= mu_ch;
                        mu_q  <= mu;
                        state <= CALC;
                    end
                    CALC: begin
                        state <= IDLE;
                        if (ch_ok) begin
                            v_q[ch_idx]   <= v_sat.value[W-1:0];
                            x_q[ch_idx]   <= x_sat.value[W-1:0];
                            dir_q[ch_idx] <= x_sat.value[W-1];
                            if (v_sat.clamped || x_sat.clamped) sat_q[ch_idx] <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [W-2:0] mag;
        assign mag = x_q[g][W-1] ? (W-1)'(-x_q[g]) : x_q[g][W-2:0];

        boreal_dds_pwm #(.MW(W-1)) u_dds (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .clr    (clr),
            .mag    (mag),
            .pwm    (pwm[g])
        );
    end

endmodule

// File: tb/tb_boreal_velocity_pwm_mc.sv
// Bench for boreal_velocity_pwm_mc: directed and random samples against an
// arithmetic reference model; a 3-channel copy covers out-of-range channels.
module tb_boreal_velocity_pwm_mc;

    localparam int LIM = 32767;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              clr;
    logic              mu_valid;
    logic              mu_ready;
    logic [0:0]        mu_ch;
    logic signed [15:0] mu;
    logic              sat_clr;
    logic [1:0]        pwm;
    logic [1:0]        dir;
    logic [1:0]        sat_flag;
    logic              busy;

    logic [1:0]        mu_ch3;
    logic              mu_ready3;
    logic [2:0]        pwm3;
    logic [2:0]        dir3;
    logic [2:0]        sat_flag3;
    logic              busy3;

    int n_cmp = 0;
    int n_err = 0;

    int mv [2];
    int mx [2];
    bit ms [2];
    int m3v [3];
    int m3x [3];
    bit m3s [3];

    boreal_velocity_pwm_mc dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
        .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_ch(mu_ch), .mu(mu),
        .sat_clr(sat_clr), .pwm(pwm), .dir(dir), .sat_flag(sat_flag), .busy(busy)
    );

    boreal_velocity_pwm_mc #(.NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
        .mu_valid(mu_valid), .mu_ready(mu_ready3), .mu_ch(mu_ch3), .mu(mu),
        .sat_clr(sat_clr), .pwm(pwm3), .dir(dir3), .sat_flag(sat_flag3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: floor division and symmetric clamp on plain integers.
    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int clampv(input int a, inout bit s);
        if (a > LIM) begin s = 1'b1; return LIM; end
        if (a < -LIM) begin s = 1'b1; return -LIM; end
        return a;
    endfunction

    task automatic upd(inout int v, inout int x, inout bit s, input int m);
        int nv, nx;
        nv = v + fdiv(m, 8) - fdiv(v, 16);
        nx = x + v;
        v  = clampv(nv, s);
        x  = clampv(nx, s);
    endtask

    task automatic model_zero_vx();
        for (int i = 0; i < 2; i++) begin mv[i] = 0; mx[i] = 0; end
        for (int i = 0; i < 3; i++) begin m3v[i] = 0; m3x[i] = 0; end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_v%0d", tag, i), dut.v_q[i], mv[i]);
            check($sformatf("%s_x%0d", tag, i), dut.x_q[i], mx[i]);
            check($sformatf("%s_dir%0d", tag, i), dir[i], mx[i] < 0);
            check($sformatf("%s_sat%0d", tag, i), sat_flag[i], ms[i]);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_n3v%0d", tag, i), dut3.v_q[i], m3v[i]);
            check($sformatf("%s_n3x%0d", tag, i), dut3.x_q[i], m3x[i]);
            check($sformatf("%s_n3sat%0d", tag, i), sat_flag3[i], m3s[i]);
        end
    endtask

    // Called just after a negedge; returns just after the negedge that
    // follows the writeback edge.
    task automatic send(input int ch, input int m, input int ch3 = 3);
        int budget;
        logic [31:0] cv;
        cv       = 32'(ch);
        mu_ch    = cv[0:0];
        cv       = 32'(ch3);
        mu_ch3   = cv[1:0];
        mu       = 16'(m);
        mu_valid = 1'b1;
        #1;
        budget = 0;
        while (!mu_ready && budget < 10) begin
            @(negedge clk); #1;
            budget++;
        end
        check("accept_wait", budget < 10, 1);
        @(negedge clk); #1;
        mu_valid = 1'b0;
        check("busy_calc", busy, 1);
        check("ready_calc", mu_ready, 0);
        @(negedge clk); #1;
        upd(mv[ch], mx[ch], ms[ch], m);
        if (ch3 < 3) upd(m3v[ch3], m3x[ch3], m3s[ch3], m);
    endtask

    initial begin
        int cnt0, cnt1;
        logic [31:0] r;
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; mu_valid = 1'b0;
        mu_ch = '0; mu_ch3 = 2'd3; mu = '0; sat_clr = 1'b0;
        model_zero_vx();
        for (int i = 0; i < 2; i++) ms[i] = 1'b0;
        for (int i = 0; i < 3; i++) m3s[i] = 1'b0;

        // Reset values
        #1;
        check("rst_pwm", pwm, 0);
        check("rst_dir", dir, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", mu_ready, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_enable_low", mu_ready, 0);
        @(negedge clk);
        enable = 1'b1;
        #1;
        check("ready_enable_high", mu_ready, 1);
        check_all("init");

        // Channel 0: two samples of +800 (3-channel copy also drives ch2 once)
        send(0, 800, 2);
        check("p1_v0", dut.v_q[0], 100);
        check("p1_x0", dut.x_q[0], 0);
        check("p1_n3v2", dut3.v_q[2], 100);
        check_all("p1");
        send(0, 800);
        check("p2_v0", dut.v_q[0], 194);
        check("p2_x0", dut.x_q[0], 100);
        check("p2_v1", dut.v_q[1], 0);
        check_all("p2");

        // Channel 1: two samples of -800
        send(1, -800);
        check("n1_v1", dut.v_q[1], -100);
        send(1, -800);
        check("n2_v1", dut.v_q[1], -193);
        check("n2_x1", dut.x_q[1], -100);
        check("n2_dir1", dir[1], 1);
        check_all("n2");

        // Exact duty over one full accumulator period
        @(negedge clk); @(negedge clk);
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 32768; k++) begin
            @(negedge clk);
            cnt0 += int'(pwm[0]);
            cnt1 += int'(pwm[1]);
        end
        check("duty0", cnt0, 100);
        check("duty1", cnt1, 100);
        #1;

        // Saturation on channel 0
        for (int k = 0; k < 20; k++) begin
            send(0, 32767);
            check("sat_nowrap", dut.v_q[0] >= 0, 1);
            check_all("sat");
        end
        check("sat_v0_max", dut.v_q[0], 32767);
        check("sat_flag0", sat_flag[0], 1);
        sat_clr = 1'b1;
        send(0, 32767);
        sat_clr = 1'b0;
        check("sat_wins", sat_flag[0], 1);
        sat_clr = 1'b1;
        @(negedge clk); #1;
        sat_clr = 1'b0;
        for (int i = 0; i < 2; i++) ms[i] = 1'b0;
        for (int i = 0; i < 3; i++) m3s[i] = 1'b0;
        check("sat_cleared", sat_flag, 0);
        check_all("satclr");

        // mu_valid held high: accept every other cycle
        mu_ch = 1'b1; mu_ch3 = 2'd3; mu = 16'sd2400; mu_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("hold_ready", mu_ready, (k % 2) == 0);
            check("hold_busy", busy, (k % 2) == 1);
            if ((k % 2) == 0) upd(mv[1], mx[1], ms[1], 2400);
            @(negedge clk); #1;
        end
        mu_valid = 1'b0;
        check_all("hold");

        // Random samples
        for (int k = 0; k < 24; k++) begin
            r = $urandom;
            send(int'(r[16]), int'($signed(r[15:0])), int'(r[18:17]));
            check_all("rnd");
        end

        // clr during CALC aborts without writeback
        mu_ch = 1'b0; mu_ch3 = 2'd0; mu = 16'sd8000; mu_valid = 1'b1;
        #1;
        check("clr_pre_ready", mu_ready, 1);
        @(negedge clk); #1;
        mu_valid = 1'b0;
        check("clr_in_calc", busy, 1);
        clr = 1'b1;
        #1;
        check("clr_ready", mu_ready, 0);
        @(negedge clk); #1;
        model_zero_vx();
        check("clr_busy", busy, 0);
        check("clr_pwm", pwm, 0);
        check("clr_pwm3", pwm3, 0);
        check_all("clr");
        clr = 1'b0;

        // enable low: PWM held off, state retained
        send(0, 800);
        send(0, 800);
        send(1, -16000);
        send(1, -16000);
        enable = 1'b0;
        @(negedge clk); #1;
        check("en_ready", mu_ready, 0);
        cnt0 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cnt0 += int'(pwm[0]) + int'(pwm[1]);
        end
        #1;
        check("en_pwm_off", cnt0, 0);
        check_all("en");
        enable = 1'b1;

        // Asynchronous reset mid-stream
        mu_ch = 1'b1; mu = -16'sd20000; mu_valid = 1'b1;
        @(negedge clk); #1;
        check("rstm_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        model_zero_vx();
        for (int i = 0; i < 2; i++) ms[i] = 1'b0;
        for (int i = 0; i < 3; i++) m3s[i] = 1'b0;
        check("rstm_busy", busy, 0);
        check("rstm_ready", mu_ready, 0);
        check("rstm_pwm", pwm, 0);
        check("rstm_dir", dir, 0);
        check_all("rstm");
        mu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
